fft_peak_detect: RTL and testbench
==================================

// Module: fft_peak_detect
// PURPOSE
//  Receives the 16-bin complex spectrum from the FFT block over its fft_valid/fft_d0..fft_d15 interface.
//  Scans the bins one per cycle and computes each bin's squared magnitude re^2+im^2.
//  Reports the index and magnitude of the strongest bin, i.e. the dominant frequency of the frame.
//  Final stage of the frequency-analysis chain: FIR -> FFT -> fft_peak_detect.
// PARAMETERS
//  DW     16  width of each signed real/imag component; fft_dN = {re[2DW-1:DW], im[DW-1:0]}
//  MAG_W  32  squared-magnitude width; localparam = 2*DW (max sum 2^(2DW-1) fits, no overflow)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  fft_valid    in   1      one-cycle strobe; fft_d0..fft_d15 valid in this cycle only
//  fft_d0..15   in   2*DW   bin k, {real, imag}, two's complement
//  done         out  1      one-cycle pulse; freq/peak_mag valid in this cycle and held until next done
//  freq         out  4      index 0..15 of the max-magnitude bin
//  peak_mag     out  MAG_W  re^2+im^2 of that bin, unsigned
//  ovf          out  1      one-cycle pulse: pending frame overwritten (frame lost)
// BEHAVIOUR
//  Reset: every register clears asynchronously; done=0, freq=0, peak_mag=0, ovf=0, FSM=IDLE, pending empty.
//  Reset mid-scan drops all in-flight frames; no done is issued for them.
//  Storage: work buffer (16 bins) plus a one-deep pending buffer.
//  FSM states: IDLE, SCAN. idx is a 4-bit counter.
//   IDLE: fft_valid=1 at edge E0 loads the work buffer, sets idx=0 and goes to SCAN.
//   SCAN: idx increments every cycle.
//    End-of-scan edge (idx==15):
//     - fft_valid=1 at the same edge: that frame loads the work buffer, idx=0, stay in SCAN.
//     - else pending full: pending moves to the work buffer, idx=0, stay in SCAN.
//     - else: go to IDLE.
//    fft_valid=1 while idx<15: frame is written to pending.
//     - If pending is already full, it is overwritten and ovf pulses.
//    fft_valid and pending at the same end-of-scan edge: live input goes first; the pending frame stays queued.
//  Pipeline:
//   stage 1: mag_r <= re(idx)^2 + im(idx)^2, signed multiplies.
//   stage 2: compare/track best.
//    - Bin 0 loads best unconditionally, which lets frames run back-to-back.
//    - Bin k>0 replaces best only if mag > best (strict), so ties keep the lowest index.
//   After bin 15 is compared: freq/peak_mag are registered and done pulses.
//  Latency: done is first high in the cycle after edge E0+18.
//   Throughput: one frame every 16 cycles sustained, with no bubbles.
//  Consecutive frames never merge; each frame yields exactly one done.
//   The exception is a frame lost on ovf, which yields none.
//  Magnitude arithmetic is exact; (-2^(DW-1))^2 is handled with no saturation.
// STRUCTURE
//  Shared package: DW, N_BINS=16, IDX_W=4, MAG_W, FSM state encodings (IDLE, SCAN).
//  Sub-module fft_bin_mag (combinational: {re,im} -> re^2+im^2), one instance feeding mag_r.
//  Top level holds the FSM, idx, the work/pending buffers, the compare stage and the output registers.
// TESTING
//  1 Single frame: bin 5 = {16'sd100, -16'sd200}, all others 0
//    -> done at E0+18, freq=5, peak_mag=50000.
//  2 Tie: bins 3 and 9 = {16'sd30, 16'sd40}, others {1,1}
//    -> freq=3, peak_mag=2500.
//  3 Extreme: bin 15 = {-32768, -32768}, others {32767, 0}
//    -> freq=15, peak_mag=32'h8000_0000.
//  4 Back-to-back: frames at E0 (peak 2) and E16 (peak 11)
//    -> done at E0+18 (freq=2) and E0+34 (freq=11), no ovf.
//  5 Early frames: frames at E0, E4 and E8
//    -> E4 frame is overwritten, ovf pulses at E8, two dones total (frames E0 and E8).
//  6 Reset at E0+10 during a scan
//    -> outputs cleared immediately; no done afterwards; the next frame is processed normally.

Source files
------------

// File: rtl/fft_peak_detect_pkg.sv
// fft_peak_detect_pkg
//  Shared constants and types for the FFT peak detector.
//  DW     width of one signed real/imag component
//  N_BINS number of spectrum bins per frame
//  IDX_W  width of the bin index
//  MAG_W  width of an unsigned squared magnitude (re^2 + im^2 always fits)
package fft_peak_detect_pkg;

    localparam int DW     = 16;
    localparam int N_BINS = 16;
    localparam int IDX_W  = 4;
    localparam int MAG_W  = 2 * DW;

    typedef logic [2*DW-1:0] bin_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/fft_bin_mag.sv
// fft_bin_mag
//  Combinational squared magnitude of one complex bin.
//  Ports:
//   bin  in   {re, im}, each DW-bit two's complement
//   mag  out  re^2 + im^2, unsigned, MAG_W bits, exact
module fft_bin_mag
    import fft_peak_detect_pkg::*;
(
    input  logic [2*DW-1:0]  bin,
    output logic [MAG_W-1:0] mag
);

    logic signed [DW-1:0]    re;
    logic signed [DW-1:0]    im;
    logic signed [MAG_W-1:0] re_x;
    logic signed [MAG_W-1:0] im_x;
    logic signed [MAG_W-1:0] re_sq;
    logic signed [MAG_W-1:0] im_sq;

    assign re = bin[2*DW-1:DW];
    assign im = bin[DW-1:0];

    // Sign-extend before multiplying so the full-width product is exact;
    // (-2^(DW-1))^2 = 2^(2DW-2) still fits as a positive signed value.
    assign re_x  = MAG_W'(re);
    assign im_x  = MAG_W'(im);
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    // Each square is at most 2^(2DW-2), so the unsigned sum never wraps.
    assign mag = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//  Scans a 16-bin complex spectrum one bin per cycle and reports the bin
//  with the largest squared magnitude (lowest index wins on ties).
//  Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high
//   fft_valid    in   one-cycle strobe, fft_d0..fft_d15 valid this cycle
//   fft_d0..15   in   bin k as {re, im}, two's complement
//   done         out  one-cycle pulse, freq/peak_mag valid and held after
//   freq         out  index of the strongest bin
//   peak_mag     out  squared magnitude of that bin
//   ovf          out  one-cycle pulse, a queued frame was overwritten
//
//  state | meaning
//  IDLE  | no frame in the work buffer, waiting for fft_valid
//  SCAN  | idx walks the work buffer; a frame arriving early goes to pending
module fft_peak_detect
    import fft_peak_detect_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fft_valid,
    input  logic [2*DW-1:0]  fft_d0,
    input  logic [2*DW-1:0]  fft_d1,
    input  logic [2*DW-1:0]  fft_d2,
    input  logic [2*DW-1:0]  fft_d3,
    input  logic [2*DW-1:0]  fft_d4,
    input  logic [2*DW-1:0]  fft_d5,
    input  logic [2*DW-1:0]  fft_d6,
    input  logic [2*DW-1:0]  fft_d7,
    input  logic [2*DW-1:0]  fft_d8,
    input  logic [2*DW-1:0]  fft_d9,
    input  logic [2*DW-1:0]  fft_d10,
    input  logic [2*DW-1:0]  fft_d11,
    input  logic [2*DW-1:0]  fft_d12,
    input  logic [2*DW-1:0]  fft_d13,
    input  logic [2*DW-1:0]  fft_d14,
    input  logic [2*DW-1:0]  fft_d15,
    output logic             done,
    output logic [IDX_W-1:0] freq,
    output logic [MAG_W-1:0] peak_mag,
    output logic             ovf
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    bin_t fft_d   [N_BINS];
    bin_t work    [N_BINS];
    bin_t pending [N_BINS];

    logic             pend_full;
    state_t           state;
    logic [IDX_W-1:0] idx;

    logic [MAG_W-1:0] mag_w;
    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic [MAG_W-1:0] mag_r;

    logic [MAG_W-1:0] best_mag;
    logic [IDX_W-1:0] best_idx;
    logic             s2_last;

    assign fft_d[0]  = fft_d0;
    assign fft_d[1]  = fft_d1;
    assign fft_d[2]  = fft_d2;
    assign fft_d[3]  = fft_d3;
    assign fft_d[4]  = fft_d4;
    assign fft_d[5]  = fft_d5;
    assign fft_d[6]  = fft_d6;
    assign fft_d[7]  = fft_d7;
    assign fft_d[8]  = fft_d8;
    assign fft_d[9]  = fft_d9;
    assign fft_d[10] = fft_d10;
    assign fft_d[11] = fft_d11;
    assign fft_d[12] = fft_d12;
    assign fft_d[13] = fft_d13;
    assign fft_d[14] = fft_d14;
    assign fft_d[15] = fft_d15;

    // Frame control: work/pending buffers, scan index and overwrite flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pend_full <= 1'b0;
            ovf       <= 1'b0;
            for (int i = 0; i < N_BINS; i++) begin
                work[i]    <= '0;
                pending[i] <= '0;
            end
        end else begin
            ovf <= 1'b0;
            case (state)
                IDLE: begin
                    if (fft_valid) begin
                        work  <= fft_d;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (idx == LAST_IDX) begin
                        // Live input wins; a queued frame waits one more scan.
                        if (fft_valid) begin
                            work <= fft_d;
                            idx  <= '0;
                        end else if (pend_full) begin
                            work      <= pending;
                            pend_full <= 1'b0;
                            idx       <= '0;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                        if (fft_valid) begin
                            pending   <= fft_d;
                            pend_full <= 1'b1;
                            ovf       <= pend_full;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fft_bin_mag u_bin_mag (
        .bin (work[idx]),
        .mag (mag_w)
    );

    // Stage 1: squared magnitude of the current bin, tagged with its index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            mag_r    <= '0;
        end else begin
            s1_valid <= (state == SCAN);
            s1_idx   <= idx;
            mag_r    <= mag_w;
        end
    end

    // Stage 2: running maximum. Bin 0 restarts the search so frames can
    // follow each other with no gap; strict compare keeps the lowest index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_mag <= '0;
            best_idx <= '0;
            s2_last  <= 1'b0;
        end else begin
            s2_last <= s1_valid && (s1_idx == LAST_IDX);
            if (s1_valid) begin
                if (s1_idx == '0) begin
                    best_mag <= mag_r;
                    best_idx <= '0;
                end else if (mag_r > best_mag) begin
                    best_mag <= mag_r;
                    best_idx <= s1_idx;
                end
            end
        end
    end

    // Stage 3: publish the result once bin 15 has been compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            freq     <= '0;
            peak_mag <= '0;
        end else begin
            done <= s2_last;
            if (s2_last) begin
                freq     <= best_idx;
                peak_mag <= best_mag;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
module tb_fft_peak_detect;

    typedef logic [31:0] frame_t [16];
    typedef struct {
        logic [3:0]  f;
        logic [31:0] m;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fft_valid = 1'b0;
    logic [31:0] d_in [16];
    logic        done;
    logic [3:0]  freq;
    logic [31:0] peak_mag;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    int e_cnt  = 0;

    exp_t   exp_q [$];
    int     ovf_q [$];
    bit     have_scan = 1'b0;
    int     scan_start = 0;
    bit     pend_v = 1'b0;
    frame_t pend_f;
    frame_t drv_frame;
    logic [3:0]  hold_f = '0;
    logic [31:0] hold_m = '0;

    always #5 clk = ~clk;

    fft_peak_detect dut (
        .clk       (clk),
        .rst       (rst),
        .fft_valid (fft_valid),
        .fft_d0    (d_in[0]),
        .fft_d1    (d_in[1]),
        .fft_d2    (d_in[2]),
        .fft_d3    (d_in[3]),
        .fft_d4    (d_in[4]),
        .fft_d5    (d_in[5]),
        .fft_d6    (d_in[6]),
        .fft_d7    (d_in[7]),
        .fft_d8    (d_in[8]),
        .fft_d9    (d_in[9]),
        .fft_d10   (d_in[10]),
        .fft_d11   (d_in[11]),
        .fft_d12   (d_in[12]),
        .fft_d13   (d_in[13]),
        .fft_d14   (d_in[14]),
        .fft_d15   (d_in[15]),
        .done      (done),
        .freq      (freq),
        .peak_mag  (peak_mag),
        .ovf       (ovf)
    );

    function automatic logic [31:0] mk(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    // Strongest bin by plain integer arithmetic; first maximum wins.
    function automatic void ref_peak(input frame_t f, output logic [3:0] pf, output logic [31:0] pm);
        longint best;
        longint re;
        longint im;
        longint m;
        best = -1;
        pf = '0;
        for (int k = 0; k < 16; k++) begin
            re = longint'($signed(f[k][31:16]));
            im = longint'($signed(f[k][15:0]));
            m  = re * re + im * im;
            if (m > best) begin
                best = m;
                pf   = k[3:0];
            end
        end
        pm = best[31:0];
    endfunction

    task automatic start_frame(input frame_t f, input int e);
        exp_t x;
        ref_peak(f, x.f, x.m);
        x.c = e + 18;
        exp_q.push_back(x);
        have_scan  = 1'b1;
        scan_start = e;
    endtask

    // Frame-level queue model: a scan occupies edges start..start+16, the
    // last of which may accept the next frame; early frames wait in a
    // single slot that can be overwritten.
    task automatic model_edge(input bit v, input int e);
        bit scanning;
        scanning = have_scan && (e <= scan_start + 16);
        if (!scanning) begin
            have_scan = 1'b0;
            if (v) start_frame(drv_frame, e);
        end else if (e == scan_start + 16) begin
            if (v) begin
                start_frame(drv_frame, e);
            end else if (pend_v) begin
                start_frame(pend_f, e);
                pend_v = 1'b0;
            end else begin
                have_scan = 1'b0;
            end
        end else if (v) begin
            if (pend_v) ovf_q.push_back(e);
            pend_f = drv_frame;
            pend_v = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at edge %0d", tag, obs, expv, e_cnt);
        end
    endtask

    task automatic check_outputs();
        exp_t x;
        bit   exp_done;
        bit   exp_ovf;
        exp_done = (exp_q.size() > 0) && (exp_q[0].c == e_cnt);
        if (exp_done) begin
            x = exp_q.pop_front();
            hold_f = x.f;
            hold_m = x.m;
        end
        exp_ovf = (ovf_q.size() > 0) && (ovf_q[0] == e_cnt);
        if (exp_ovf) void'(ovf_q.pop_front());
        check("done", 32'(done), 32'(exp_done));
        check("freq", 32'(freq), 32'(hold_f));
        check("peak_mag", peak_mag, hold_m);
        check("ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic step(input bit v);
        fft_valid = v;
        for (int k = 0; k < 16; k++) d_in[k] = v ? drv_frame[k] : $urandom();
        e_cnt++;
        model_edge(v, e_cnt);
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic fill(input int re, input int im);
        for (int k = 0; k < 16; k++) drv_frame[k] = mk(re, im);
    endtask

    task automatic ramp_with_peak(input int pk);
        for (int k = 0; k < 16; k++) drv_frame[k] = mk(k * 3, -k);
        drv_frame[pk] = mk(1000, 500);
    endtask

    task automatic rand_frame();
        int mode;
        mode = $urandom_range(0, 3);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0: drv_frame[k] = $urandom();
                1: drv_frame[k] = mk($urandom_range(0, 3) - 1, $urandom_range(0, 3) - 1);
                2: drv_frame[k] = ($urandom_range(0, 1) == 0) ? 32'h8000_8000 : 32'h7fff_8001;
                default: drv_frame[k] = mk($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100);
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            d_in[k] = '0;
            drv_frame[k] = '0;
            pend_f[k] = '0;
        end
        #1 rst = 1'b1;
        #1;
        check("reset_done", 32'(done), 32'd0);
        check("reset_freq", 32'(freq), 32'd0);
        check("reset_peak_mag", peak_mag, 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Single frame with one strong bin.
        fill(0, 0);
        drv_frame[5] = mk(100, -200);
        step(1'b1);
        idle(25);
        check("t1_freq", 32'(freq), 32'd5);
        check("t1_peak_mag", peak_mag, 32'd50000);

        // Equal maxima: the lower index is reported.
        fill(1, 1);
        drv_frame[3] = mk(30, 40);
        drv_frame[9] = mk(30, 40);
        step(1'b1);
        idle(25);
        check("t2_freq", 32'(freq), 32'd3);
        check("t2_peak_mag", peak_mag, 32'd2500);

        // Most negative components give the largest possible magnitude.
        fill(32767, 0);
        drv_frame[15] = mk(-32768, -32768);
        step(1'b1);
        idle(25);
        check("t3_freq", 32'(freq), 32'd15);
        check("t3_peak_mag", peak_mag, 32'h8000_0000);

        // Back-to-back frames 16 edges apart.
        ramp_with_peak(2);
        step(1'b1);
        idle(15);
        ramp_with_peak(11);
        step(1'b1);
        idle(30);
        check("t4_freq", 32'(freq), 32'd11);

        // Frames at E0, E4, E8: the E4 frame is lost.
        ramp_with_peak(1);
        step(1'b1);
        idle(3);
        ramp_with_peak(7);
        step(1'b1);
        idle(3);
        ramp_with_peak(12);
        step(1'b1);
        idle(35);
        check("t5_freq", 32'(freq), 32'd12);

        // Reset in the middle of a scan with a frame also queued.
        ramp_with_peak(4);
        step(1'b1);
        idle(3);
        ramp_with_peak(9);
        step(1'b1);
        idle(6);
        rst = 1'b1;
        #1;
        exp_q.delete();
        ovf_q.delete();
        have_scan = 1'b0;
        pend_v = 1'b0;
        hold_f = '0;
        hold_m = '0;
        check("rst_done", 32'(done), 32'd0);
        check("rst_freq", 32'(freq), 32'd0);
        check("rst_peak_mag", peak_mag, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(20);
        ramp_with_peak(6);
        step(1'b1);
        idle(25);
        check("t6_freq", 32'(freq), 32'd6);

        // Random traffic: sparse, back-to-back and early frames.
        for (int i = 0; i < 500; i++) begin
            rand_frame();
            step($urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 6; i++) begin
            rand_frame();
            step(1'b1);
            idle(15);
        end
        idle(40);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
